// File: rtl/barrier_collision_judge_if.sv
// Handshake bundle between the sprite pipeline / top-level FSM and barrier_collision_judge.
// The master drives pixel hits and strobes; the slave (the judge) returns game status.
interface barrier_collision_judge_if #(
  parameter int N_BARRIERS = 3,
  parameter int SCORE_W    = 16
);
  logic                  i_frame_end;
  logic                  i_game_start;
  logic                  i_player_hit;
  logic [N_BARRIERS-1:0] i_barrier_hit;
  logic [N_BARRIERS-1:0] i_barrier_in_pos;
  logic [3:0]            o_lives;
  logic                  o_collision;
  logic [N_BARRIERS-1:0] o_hit_mask;
  logic                  o_invuln;
  logic                  o_game_over;
  logic [SCORE_W-1:0]    o_score;
  logic                  o_player_visible;

  modport master (
    output i_frame_end, i_game_start, i_player_hit, i_barrier_hit, i_barrier_in_pos,
    input  o_lives, o_collision, o_hit_mask, o_invuln, o_game_over, o_score,
           o_player_visible
  );

  modport slave (
    input  i_frame_end, i_game_start, i_player_hit, i_barrier_hit, i_barrier_in_pos,
    output o_lives, o_collision, o_hit_mask, o_invuln, o_game_over, o_score,
           o_player_visible
  );
endinterface

// File: rtl/barrier_collision_judge.sv
// Per-frame player/barrier collision judge: lives, invulnerability, game-over and score.
// Optional player blink during invulnerability is enabled by defining BARRIER_JUDGE_BLINK_EN.
module barrier_collision_judge #(
  parameter int N_BARRIERS    = 3,
  parameter int START_LIVES   = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int SCORE_W       = 16
) (
  input logic                     i_clk,
  input logic                     i_rst,
  barrier_collision_judge_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAYING,
    ST_INVULN,
    ST_GAME_OVER
  } state_t;

  localparam logic [3:0]         LIVES_INIT  = 4'(START_LIVES);
  localparam logic [7:0]         INVULN_INIT = 8'(INVULN_FRAMES);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
  localparam logic [SCORE_W-1:0] SCORE_ONE   = SCORE_W'(1);

  state_t                state_q, state_d;
  logic [3:0]            lives_q, lives_d;
  logic [N_BARRIERS-1:0] overlap_q, overlap_d;
  logic [N_BARRIERS-1:0] hit_mask_q, hit_mask_d;
  logic [7:0]            invuln_cnt_q, invuln_cnt_d;
  logic [SCORE_W-1:0]    score_q, score_d;
  logic                  collision_q, collision_d;

  logic                  active;
  logic [N_BARRIERS-1:0] pixel_hit;
  logic [N_BARRIERS-1:0] overlap_now;
  logic [SCORE_W-1:0]    score_inc;

  assign active      = (state_q == ST_PLAYING) || (state_q == ST_INVULN);
  assign pixel_hit   = {N_BARRIERS{bus.i_player_hit}} & bus.i_barrier_hit & bus.i_barrier_in_pos;
  // The pixel coinciding with the frame-end strobe still belongs to the ending frame.
  assign overlap_now = overlap_q | pixel_hit;
  assign score_inc   = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_ONE;

  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    hit_mask_d   = hit_mask_q;
    invuln_cnt_d = invuln_cnt_q;
    score_d      = score_q;
    collision_d  = 1'b0;
    overlap_d    = active ? overlap_now : '0;

    if (bus.i_frame_end) begin
      overlap_d = '0;
    end

    case (state_q)
      ST_PLAYING: begin
        if (bus.i_frame_end) begin
          if (overlap_now != '0) begin
            collision_d = 1'b1;
            hit_mask_d  = overlap_now;
            if (lives_q <= 4'd1) begin
              lives_d = 4'd0;
              state_d = ST_GAME_OVER;
            end else begin
              lives_d      = lives_q - 4'd1;
              invuln_cnt_d = INVULN_INIT;
              state_d      = ST_INVULN;
            end
          end else begin
            score_d = score_inc;
          end
        end
      end
      ST_INVULN: begin
        if (bus.i_frame_end) begin
          score_d = score_inc;
          if (invuln_cnt_q <= 8'd1) begin
            invuln_cnt_d = 8'd0;
            state_d      = ST_PLAYING;
          end else begin
            invuln_cnt_d = invuln_cnt_q - 8'd1;
          end
        end
      end
      default: begin
      end
    endcase

    // A start strobe overrides any same-cycle frame decision.
    if (bus.i_game_start) begin
      state_d      = ST_PLAYING;
      lives_d      = LIVES_INIT;
      score_d      = '0;
      invuln_cnt_d = 8'd0;
      collision_d  = 1'b0;
      overlap_d    = '0;
      if (state_q == ST_GAME_OVER) begin
        hit_mask_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      lives_q      <= LIVES_INIT;
      overlap_q    <= '0;
      hit_mask_q   <= '0;
      invuln_cnt_q <= 8'd0;
      score_q      <= '0;
      collision_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      overlap_q    <= overlap_d;
      hit_mask_q   <= hit_mask_d;
      invuln_cnt_q <= invuln_cnt_d;
      score_q      <= score_d;
      collision_q  <= collision_d;
    end
  end

  assign bus.o_lives     = lives_q;
  assign bus.o_collision = collision_q;
  assign bus.o_hit_mask  = hit_mask_q;
  assign bus.o_invuln    = (state_q == ST_INVULN);
  assign bus.o_game_over = (state_q == ST_GAME_OVER);
  assign bus.o_score     = score_q;

`ifdef BARRIER_JUDGE_BLINK_EN
  logic [1:0] blink_cnt_q, blink_cnt_d;
  logic       visible_q, visible_d;

  // Toggle on every 4th frame end spent invulnerable; always visible otherwise.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    visible_d   = visible_q;
    if (state_q == ST_INVULN && bus.i_frame_end && !bus.i_game_start) begin
      blink_cnt_d = blink_cnt_q + 2'd1;
      if (blink_cnt_q == 2'd3) begin
        visible_d = ~visible_q;
      end
    end
    if (state_d != ST_INVULN) begin
      blink_cnt_d = 2'd0;
      visible_d   = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      blink_cnt_q <= 2'd0;
      visible_q   <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      visible_q   <= visible_d;
    end
  end

  assign bus.o_player_visible = visible_q;
`else
  assign bus.o_player_visible = 1'b1;
`endif

endmodule

// File: tb/tb_barrier_collision_judge.sv
// Randomized frame-level bench for barrier_collision_judge, checked against a
// per-frame game model (lives, invulnerability frames left, score) kept in the bench.
module tb_barrier_collision_judge;

  localparam int NB      = 3;
  localparam int LIVES0  = 3;
  localparam int INVULN  = 60;
  localparam int SW      = 16;
  localparam int SMAX    = 65535;

  logic clk = 1'b0;
  logic rst;

  barrier_collision_judge_if #(.N_BARRIERS(NB), .SCORE_W(SW)) bus ();

  barrier_collision_judge #(
    .N_BARRIERS(NB), .START_LIVES(LIVES0), .INVULN_FRAMES(INVULN), .SCORE_W(SW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int evaluated = 0;
  int failures  = 0;

  // Game model: one update per frame, expressed as lives and frames left to wait.
  bit mStarted, mGameOver, mCollision;
  int mLives, mScore, mInvulnLeft, mMask;

  function automatic int expVisible();
`ifdef BARRIER_JUDGE_BLINK_EN
    if (mStarted && !mGameOver && mInvulnLeft > 0)
      return (((INVULN - mInvulnLeft) / 4) % 2 == 0) ? 1 : 0;
`endif
    return 1;
  endfunction

  task automatic modelReset();
    mStarted = 0; mGameOver = 0; mCollision = 0;
    mLives = LIVES0; mScore = 0; mInvulnLeft = 0; mMask = 0;
  endtask

  task automatic modelStart();
    if (mGameOver) mMask = 0;
    mStarted = 1; mGameOver = 0; mCollision = 0;
    mLives = LIVES0; mScore = 0; mInvulnLeft = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveIdle();
    bus.i_frame_end      = 1'b0;
    bus.i_game_start     = 1'b0;
    bus.i_player_hit     = 1'b0;
    bus.i_barrier_hit    = '0;
    bus.i_barrier_in_pos = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    evaluated++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string ctx);
    checkOutput({ctx, "/lives"},     32'(bus.o_lives),          32'(mLives));
    checkOutput({ctx, "/collision"}, 32'(bus.o_collision),      32'(mCollision));
    checkOutput({ctx, "/hit_mask"},  32'(bus.o_hit_mask),       32'(mMask));
    checkOutput({ctx, "/invuln"},    32'(bus.o_invuln),         32'(mStarted && !mGameOver && mInvulnLeft > 0));
    checkOutput({ctx, "/game_over"}, 32'(bus.o_game_over),      32'(mGameOver));
    checkOutput({ctx, "/score"},     32'(bus.o_score),          32'(mScore));
    checkOutput({ctx, "/visible"},   32'(bus.o_player_visible), 32'(expVisible()));
  endtask

  // One frame of pixels; forceMask lanes overlap on one random pixel, inPosKill
  // clears in-position bits, startAtEnd fires game_start together with frame_end.
  task automatic applyStimulus(input logic [2:0] forceMask, input bit randomHits,
                               input logic [2:0] inPosKill, input bit startAtEnd,
                               input string ctx);
    int nPix     = int'($urandom_range(6, 16));
    int forcePix = int'($urandom_range(0, nPix - 1));
    logic [2:0] acc = '0;
    bit active = mStarted && !mGameOver;
    for (int p = 0; p < nPix; p++) begin
      logic       ph = 1'($urandom);
      logic [2:0] bh = 3'($urandom);
      logic [2:0] ip = 3'($urandom);
      if (!randomHits) ip = ip & ~bh;
      if (p == forcePix && forceMask != '0) begin
        ph = 1'b1; bh = bh | forceMask; ip = ip | forceMask;
      end
      ip = ip & ~inPosKill;
      bus.i_player_hit     = ph;
      bus.i_barrier_hit    = bh;
      bus.i_barrier_in_pos = ip;
      bus.i_frame_end      = (p == nPix - 1);
      bus.i_game_start     = startAtEnd && (p == nPix - 1);
      if (ph && active) acc = acc | (bh & ip);
      tick();
    end
    driveIdle();
    mCollision = 0;
    if (startAtEnd) begin
      modelStart();
    end else if (active) begin
      if (mInvulnLeft > 0) begin
        mInvulnLeft--;
        mScore = (mScore < SMAX) ? mScore + 1 : SMAX;
      end else if (acc != '0) begin
        mCollision = 1;
        mMask = int'(acc);
        mLives = (mLives > 0) ? mLives - 1 : 0;
        if (mLives == 0) mGameOver = 1;
        else mInvulnLeft = INVULN;
      end else begin
        mScore = (mScore < SMAX) ? mScore + 1 : SMAX;
      end
    end
    checkAll(ctx);
    tick();
    mCollision = 0;
    checkOutput({ctx, "/pulse_end"}, 32'(bus.o_collision), 32'(0));
  endtask

  task automatic gameStart(input string ctx);
    driveIdle();
    bus.i_game_start = 1'b1;
    tick();
    bus.i_game_start = 1'b0;
    modelStart();
    checkAll(ctx);
  endtask

  initial begin
    driveIdle();
    rst = 1'b1;
    modelReset();
    repeat (3) tick();
    checkAll("reset");
    rst = 1'b0;
    tick();

    // Overlaps while idle must not change anything.
    applyStimulus(3'b111, 1'b1, 3'b000, 1'b0, "idle_frame");
    applyStimulus(3'b010, 1'b1, 3'b000, 1'b0, "idle_frame");

    gameStart("start");

    applyStimulus(3'b010, 1'b0, 3'b000, 1'b0, "lane1_hit");
    checkOutput("lane1_hit/mask_010", 32'(bus.o_hit_mask), 32'h2);

    // Lane 0 overlaps but is never in position: ten clean frames.
    gameStart("restart_in_invuln");
    for (int f = 0; f < 10; f++)
      applyStimulus(3'b001, 1'b0, 3'b001, 1'b0, "not_in_pos");
    checkOutput("not_in_pos/score_10", 32'(bus.o_score), 32'd10);

    applyStimulus(3'b010, 1'b0, 3'b000, 1'b1, "start_wins");

    // Hit, then sixty invulnerable frames full of overlaps, then a hit on frame 61.
    applyStimulus(3'b100, 1'b0, 3'b000, 1'b0, "invuln_entry");
    for (int f = 0; f < INVULN; f++)
      applyStimulus(3'($urandom_range(1, 7)), 1'b1, 3'b000, 1'b0, "invuln_window");
    checkOutput("invuln_window/lives_2", 32'(bus.o_lives), 32'd2);
    applyStimulus(3'b001, 1'b0, 3'b000, 1'b0, "frame61");
    checkOutput("frame61/lives_1", 32'(bus.o_lives), 32'd1);

    // Three separated hits from a fresh game end it.
    gameStart("restart3");
    for (int h = 0; h < 3; h++) begin
      applyStimulus(3'b001 << (h % 3), 1'b0, 3'b000, 1'b0, "three_hits");
      if (h < 2)
        for (int f = 0; f < INVULN; f++)
          applyStimulus(3'b000, 1'b0, 3'b000, 1'b0, "three_hits_wait");
    end
    checkOutput("three_hits/game_over", 32'(bus.o_game_over), 32'd1);
    for (int f = 0; f < 3; f++)
      applyStimulus(3'b111, 1'b1, 3'b000, 1'b0, "over_hold");
    gameStart("start_from_over");

    applyStimulus(3'b101, 1'b0, 3'b000, 1'b0, "two_lanes");
    checkOutput("two_lanes/mask_101", 32'(bus.o_hit_mask), 32'h5);

    // Asynchronous reset in the middle of an overlapping frame.
    for (int p = 0; p < 3; p++) begin
      bus.i_player_hit = 1'b1; bus.i_barrier_hit = 3'b111; bus.i_barrier_in_pos = 3'b111;
      tick();
    end
    #2 rst = 1'b1;
    #1 modelReset();
    checkAll("mid_reset");
    driveIdle();
    tick();
    rst = 1'b0;
    tick();
    checkAll("after_reset");

    // Free-running random play with occasional restarts.
    gameStart("random_start");
    for (int f = 0; f < 120; f++) begin
      logic [2:0] fm = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      applyStimulus(fm, 1'b0, 3'b000, 1'b0, "random");
      if ($urandom_range(0, 40) == 0) gameStart("random_restart");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule
